// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug-side reader for the register file's synchronous read port 1.
//   After a start pulse it reads every architectural register in ascending
//   index order, one at a time. Each (index, value) pair is streamed out over
//   a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        dump request, sampled only while idle
//   busy         dump in progress (ISSUE .. DONE inclusive)
//   done         one-cycle pulse after the last pair is accepted
//   rf_rs1       read address driven to register file port 1
//   rf_we        register file write-enable; a read is captured only when low
//   rf_rd1       register file read data 1 (one-cycle synchronous)
//   dump_valid   output pair valid
//   dump_ready   consumer ready
//   dump_idx     register index of the current pair
//   dump_data    register value of the current pair
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_DATA_WIDTH = 5,
  parameter bit          SKIP_X0        = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [REG_DATA_WIDTH-1:0] rf_rs1,
  input  logic                      rf_we,
  input  logic [DATA_WIDTH-1:0]     rf_rd1,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [REG_DATA_WIDTH-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0]     dump_data
);

  localparam logic [REG_DATA_WIDTH-1:0] FIRST_IDX = REG_DATA_WIDTH'(SKIP_X0 ? 1 : 0);
  localparam logic [REG_DATA_WIDTH-1:0] LAST_IDX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    OUT,
    DONE
  } state_t;

  state_t                    state;
  logic [REG_DATA_WIDTH-1:0] idx;

  // rf_rs1 is registered alongside idx so it already equals idx on entry to
  // ISSUE and holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      rf_rs1     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= FIRST_IDX;
            rf_rs1 <= FIRST_IDX;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // The register file blocks the read in any cycle it is writing.
          if (!rf_we) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          dump_data  <= rf_rd1;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx    <= idx + 1'b1;
              rf_rs1 <= idx + 1'b1;
              state  <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Scoreboard bench: two readers (SKIP_X0=0 and SKIP_X0=1) share a small
//   register file model. Expected pairs are queued by the stimulus and popped
//   by a negedge monitor on every accepted handshake.
module tb_regfile_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk;
  logic rst_n;

  logic          start_a, busy_a, done_a, dv_a, dr_a;
  logic [RW-1:0] rs1_a, didx_a;
  logic [DW-1:0] rd1_a, ddata_a;

  logic          start_b, busy_b, done_b, dv_b, dr_b;
  logic [RW-1:0] rs1_b, didx_b;
  logic [DW-1:0] rd1_b, ddata_b;

  logic          rf_we;
  logic [RW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [32];

  typedef struct {
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
  } pair_t;

  pair_t q_a[$];
  pair_t q_b[$];
  pair_t e_a, e_b;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  int          pops_b = 0;
  int unsigned cyc = 0;
  int unsigned done_cyc_a = 0;
  int unsigned s_cyc;

  regfile_dump_reader #(.DATA_WIDTH(DW), .REG_DATA_WIDTH(RW), .SKIP_X0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .rf_rs1(rs1_a), .rf_we(rf_we), .rf_rd1(rd1_a),
    .dump_valid(dv_a), .dump_ready(dr_a), .dump_idx(didx_a), .dump_data(ddata_a)
  );

  regfile_dump_reader #(.DATA_WIDTH(DW), .REG_DATA_WIDTH(RW), .SKIP_X0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .rf_rs1(rs1_b), .rf_we(rf_we), .rf_rd1(rd1_b),
    .dump_valid(dv_b), .dump_ready(dr_b), .dump_idx(didx_b), .dump_data(ddata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: writes win; the read port only captures when not writing.
  always @(posedge clk) begin
    if (rf_we) begin
      mem[waddr] <= wdata;
    end else begin
      rd1_a <= mem[rs1_a];
      rd1_b <= mem[rs1_b];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dv_a && dr_a) begin
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL pair_a: got idx=%0d data=%h, required no pair", didx_a, ddata_a);
        end else begin
          e_a = q_a.pop_front();
          if (didx_a !== e_a.idx || ddata_a !== e_a.data) begin
            fails++;
            $display("FAIL pair_a: got idx=%0d data=%h, required idx=%0d data=%h",
                     didx_a, ddata_a, e_a.idx, e_a.data);
          end
        end
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dv_b && dr_b) begin
        tests++;
        pops_b++;
        if (q_b.size() == 0) begin
          fails++;
          $display("FAIL pair_b: got idx=%0d data=%h, required no pair", didx_b, ddata_b);
        end else begin
          e_b = q_b.pop_front();
          if (didx_b !== e_b.idx || ddata_b !== e_b.data) begin
            fails++;
            $display("FAIL pair_b: got idx=%0d data=%h, required idx=%0d data=%h",
                     didx_b, ddata_b, e_b.idx, e_b.data);
          end
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where pair k is presented (and accepted, if need_rdy).
  task automatic wait_a(input int k, input bit need_rdy);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dv_a && didx_a == RW'(k) && (dr_a || !need_rdy)) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_a: got no pair idx %0d, required within 400 cycles", k);
    end
  endtask

  task automatic wait_done(input bit sel_b);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sel_b ? done_b : done_a) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_done: got no done pulse, required within 400 cycles");
    end
  endtask

  task automatic preload();
    rf_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waddr = RW'(i);
      wdata = 32'h100 + DW'(i);
      tick();
    end
    rf_we = 1'b0;
  endtask

  task automatic push_a(input int lo, input int hi);
    pair_t p;
    for (int i = lo; i <= hi; i++) begin
      p.idx  = RW'(i);
      p.data = 32'h100 + DW'(i);
      q_a.push_back(p);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    pair_t p;
    rst_n   = 1'b1;
    start_a = 1'b0; dr_a = 1'b0;
    start_b = 1'b0; dr_b = 1'b0;
    rf_we   = 1'b0; waddr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    #21;
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_valid", dv_a, 0);
    chk("reset_idx", didx_a, 0);
    chk("reset_data", ddata_a, 0);
    chk("reset_rs1", rs1_a, 0);
    rst_n = 1'b1;
    tick();

    // Plain full dump, with a start attempt in the DONE cycle.
    preload();
    push_a(0, 31);
    dr_a = 1'b1;
    pulse_start_a();
    s_cyc = cyc;
    chk("busy_after_start", busy_a, 1);
    wait_a(31, 1'b1);
    tick();
    chk("done_in_done", done_a, 1);
    chk("busy_in_done", busy_a, 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("done_one_cycle", done_a, 0);
    chk("busy_after_done", busy_a, 0);
    tick(); tick(); tick();
    chk("start_in_done_ignored", busy_a, 0);
    chk("done_latency", done_cyc_a - s_cyc, 96);
    chk("done_count_1", done_cnt_a, 1);
    chk("queue_empty_1", q_a.size(), 0);

    // Backpressure, late write, write-enable stall, early write.
    preload();
    push_a(0, 31);
    q_a[10].data = 32'hDEADBEEF;
    dr_a = 1'b1;
    pulse_start_a();
    wait_a(1, 1'b1);
    tick();
    dr_a = 1'b0;
    wait_a(2, 1'b0);
    for (int j = 0; j < 7; j++) begin
      if (j > 0) @(negedge clk);
      chk("hold_valid", dv_a, 1);
      chk("hold_idx", didx_a, 2);
      chk("hold_data", ddata_a, 32'h102);
    end
    tick();
    dr_a = 1'b1;
    wait_a(3, 1'b1);
    tick();
    rf_we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    tick();
    rf_we = 1'b0;
    wait_a(4, 1'b1);
    tick();
    rf_we = 1'b1; waddr = 5'd31; wdata = 32'h11F;
    for (int j = 0; j < 4; j++) begin
      chk("stall_rs1", rs1_a, 5);
      chk("stall_valid", dv_a, 0);
      chk("stall_busy", busy_a, 1);
      tick();
    end
    rf_we = 1'b0;
    wait_a(9, 1'b1);
    rf_we = 1'b1; waddr = 5'd10; wdata = 32'hDEADBEEF;
    tick();
    rf_we = 1'b0;
    wait_done(1'b0);
    tick();
    chk("queue_empty_2", q_a.size(), 0);
    chk("done_count_2", done_cnt_a, 2);

    // Asynchronous reset while pair 20 is waiting in OUT.
    preload();
    push_a(0, 19);
    dr_a = 1'b1;
    pulse_start_a();
    wait_a(19, 1'b1);
    tick();
    dr_a = 1'b0;
    wait_a(20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", dv_a, 0);
    chk("areset_busy", busy_a, 0);
    chk("areset_idx", didx_a, 0);
    chk("areset_data", ddata_a, 0);
    chk("areset_rs1", rs1_a, 0);
    chk("queue_empty_3", q_a.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("areset_done_count", done_cnt_a, 2);
    push_a(0, 31);
    dr_a = 1'b1;
    pulse_start_a();
    wait_done(1'b0);
    tick();
    chk("queue_empty_4", q_a.size(), 0);
    chk("done_count_4", done_cnt_a, 3);

    // SKIP_X0 instance with a second start while busy.
    for (int i = 1; i <= 31; i++) begin
      p.idx  = RW'(i);
      p.data = 32'h100 + DW'(i);
      q_b.push_back(p);
    end
    dr_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick(); tick(); tick(); tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("skip_busy", busy_b, 1);
    wait_done(1'b1);
    tick();
    tick(); tick(); tick(); tick(); tick();
    chk("skip_queue_empty", q_b.size(), 0);
    chk("skip_pairs", pops_b, 31);
    chk("skip_done_count", done_cnt_b, 1);
    chk("skip_idle", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
